// File: rtl/prog_sequencer_pkg.sv
// Shared definitions for the program-run sequencer.
//   seq_state_t  : run-level FSM states
//   stall_width  : width of the load-stall down-counter for a given memory latency (min 1)
package prog_sequencer_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_INIT,
        SEQ_EXEC,
        SEQ_WAIT,
        SEQ_DONE
    } seq_state_t;

    // A latency of 0 never stalls but still needs a 1-bit register to keep widths legal.
    function automatic int unsigned stall_width(input int unsigned lat);
        return (lat > 0) ? $clog2(lat + 1) : 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk_i  : clock
//   rst_ni : synchronous active-low reset (clears the count)
//   clr_i  : restart the count from 0 this cycle (an increment in the same cycle still applies)
//   inc_i  : add one, holding at all-ones instead of wrapping
//   q_o    : current count
module sat_counter
    import prog_sequencer_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q, q_d, base;

    always_comb begin
        base = clr_i ? '0 : q_q;
        q_d  = base;
        if (inc_i && (base != '1)) begin
            q_d = base + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/prog_sequencer.sv
// Run-level sequencer for the 9-bit core: PC init, execute, load stalls, halt.
// Gates the decoder's write enables so loads wait MEM_LAT cycles for data memory and nothing
// writes after the program acknowledges completion.
// Optional watchdog: define PROG_SEQ_WDOG_EN to end a run when the cycle count reaches WDOG_MAX.
//   clk_i           : clock, all state on rising edge
//   reset_ni        : synchronous active-low reset
//   start_i         : run request (level)
//   ack_i           : decoded "done with program" instruction
//   load_inst_i     : decoded load
//   reg_wr_en_i     : decoded reg_file write enable
//   mem_wr_en_i     : decoded data-memory write enable
//   pc_init_o       : one-cycle pulse, fetch unit loads PC = 0
//   pc_en_o         : fetch unit advances this cycle
//   reg_wr_gate_o   : qualified reg_file write enable
//   mem_wr_gate_o   : qualified data-memory write enable
//   busy_o          : run in progress (INIT/EXEC/WAIT)
//   done_o          : run finished
//   timeout_o       : run ended by the watchdog
//   cycle_cnt_o     : cycles spent in INIT/EXEC/WAIT this run
//   inst_cnt_o      : instructions retired this run
module prog_sequencer
    import prog_sequencer_pkg::*;
#(
    parameter int unsigned MEM_LAT  = 1,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned WDOG_MAX = 32'hFFF0
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             start_i,
    input  logic             ack_i,
    input  logic             load_inst_i,
    input  logic             reg_wr_en_i,
    input  logic             mem_wr_en_i,
    output logic             pc_init_o,
    output logic             pc_en_o,
    output logic             reg_wr_gate_o,
    output logic             mem_wr_gate_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] inst_cnt_o
);

    localparam int unsigned       StallW     = stall_width(MEM_LAT);
    localparam logic [StallW-1:0] StallInit  = StallW'(MEM_LAT);
    localparam logic [CNT_W-1:0]  WdogLimit  = CNT_W'(WDOG_MAX);
    localparam bit                LoadStalls = (MEM_LAT > 0);
`ifdef PROG_SEQ_WDOG_EN
    localparam bit                WdogEn     = 1'b1;
`else
    localparam bit                WdogEn     = 1'b0;
`endif

    seq_state_t        state_q;
    logic [StallW-1:0] stall_q;
    logic              timeout_q;

    logic in_run, wdog_hit, ld_stall, exec_normal, wait_last;
    logic cyc_inc, inst_inc, cnt_clr;

    always_comb begin
        in_run      = (state_q == SEQ_EXEC) || (state_q == SEQ_WAIT);
        // Watchdog wins over everything else in the cycle it fires.
        wdog_hit    = WdogEn && in_run && (cycle_cnt_o == WdogLimit);
        ld_stall    = (state_q == SEQ_EXEC) && !wdog_hit && !ack_i && load_inst_i && LoadStalls;
        exec_normal = (state_q == SEQ_EXEC) && !wdog_hit && !ack_i && !ld_stall;
        wait_last   = (state_q == SEQ_WAIT) && !wdog_hit && (stall_q == StallW'(1));

        pc_init_o     = (state_q == SEQ_INIT);
        busy_o        = (state_q == SEQ_INIT) || in_run;
        done_o        = (state_q == SEQ_DONE);
        timeout_o     = WdogEn && timeout_q;
        pc_en_o       = exec_normal || wait_last;
        reg_wr_gate_o = pc_en_o && reg_wr_en_i;
        mem_wr_gate_o = exec_normal && mem_wr_en_i && !load_inst_i;

        // The terminating cycle (Ack or watchdog) is counted in neither counter;
        // INIT clears and counts itself, so CycleCnt reads 1 in the first EXEC cycle.
        cnt_clr  = (state_q == SEQ_INIT);
        cyc_inc  = (state_q == SEQ_INIT) || exec_normal || ld_stall ||
                   ((state_q == SEQ_WAIT) && !wdog_hit);
        inst_inc = exec_normal || wait_last;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q   <= SEQ_IDLE;
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                SEQ_IDLE: begin
                    if (start_i) state_q <= SEQ_INIT;
                end
                SEQ_INIT: begin
                    timeout_q <= 1'b0;
                    state_q   <= SEQ_EXEC;
                end
                SEQ_EXEC: begin
                    if (wdog_hit) begin
                        timeout_q <= 1'b1;
                        state_q   <= SEQ_DONE;
                    end else if (ack_i) begin
                        state_q <= SEQ_DONE;
                    end else if (ld_stall) begin
                        stall_q <= StallInit;
                        state_q <= SEQ_WAIT;
                    end
                end
                SEQ_WAIT: begin
                    if (wdog_hit) begin
                        timeout_q <= 1'b1;
                        state_q   <= SEQ_DONE;
                    end else if (stall_q == StallW'(1)) begin
                        state_q <= SEQ_EXEC;
                    end else begin
                        stall_q <= stall_q - StallW'(1);
                    end
                end
                SEQ_DONE: begin
                    if (!start_i) state_q <= SEQ_IDLE;
                end
                default: state_q <= SEQ_IDLE;
            endcase
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_cycle_cnt (
        .clk_i  (clk_i),
        .rst_ni (reset_ni),
        .clr_i  (cnt_clr),
        .inc_i  (cyc_inc),
        .q_o    (cycle_cnt_o)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_inst_cnt (
        .clk_i  (clk_i),
        .rst_ni (reset_ni),
        .clr_i  (cnt_clr),
        .inc_i  (inst_inc),
        .q_o    (inst_cnt_o)
    );

endmodule
